// File: rtl/instr_decoder_pkg.sv
// Opcode/funct values and control-field encodings shared by the instruction decoder.
package instr_decoder_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] F_SLL  = 6'b000000;
    localparam logic [5:0] F_SRL  = 6'b000010;
    localparam logic [5:0] F_SRA  = 6'b000011;
    localparam logic [5:0] F_SLLV = 6'b000100;
    localparam logic [5:0] F_SRLV = 6'b000110;
    localparam logic [5:0] F_SRAV = 6'b000111;
    localparam logic [5:0] F_JR   = 6'b001000;
    localparam logic [5:0] F_JALR = 6'b001001;
    localparam logic [5:0] F_SLT  = 6'b101010;
    localparam logic [5:0] F_SLTU = 6'b101011;

    localparam logic [4:0] RT_BLTZ = 5'b00000;
    localparam logic [4:0] RT_BGEZ = 5'b00001;

    localparam logic [3:0] AF_ADD = 4'b0000;
    localparam logic [3:0] AF_LUI = 4'b1100;

    localparam logic [3:0] BF_BLTZ = 4'b0001;
    localparam logic [3:0] BF_BGEZ = 4'b0010;
    localparam logic [3:0] BF_BEQ  = 4'b0011;
    localparam logic [3:0] BF_BNE  = 4'b0100;
    localparam logic [3:0] BF_BLEZ = 4'b0101;
    localparam logic [3:0] BF_BGTZ = 4'b0110;

    localparam logic [1:0] GP_ALU   = 2'b00;
    localparam logic [1:0] GP_MEM   = 2'b01;
    localparam logic [1:0] GP_LINK  = 2'b10;
    localparam logic [1:0] GP_SHIFT = 2'b11;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu_mux_sel;
        logic [4:0] cad;
        logic       gp_we;
        logic [1:0] gp_mux_sel;
        logic [3:0] bf;
        logic       dm_we;
        logic [2:0] shift_type;
        logic [1:0] pc_mux_sel;
    } ctrl_t;

    // Bit 2 marks variable shifts; the low two bits follow funct except SLL/SLLV (00 -> 01).
    function automatic logic [2:0] shift_code(input logic [5:0] funct);
        return {funct[2], (funct[1:0] == 2'b00) ? 2'b01 : funct[1:0]};
    endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Combinational instruction decode into the full control bundle.
// Latency: 0 (pure logic). Backpressure: none.
module instr_decode_comb
    import instr_decoder_pkg::*;
(
    input  logic [31:0] instruction,
    output ctrl_t       ctrl
);

    logic [5:0] opcode;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
    logic [9:0] unused_fields;

    assign opcode        = instruction[31:26];
    assign rt            = instruction[20:16];
    assign rd            = instruction[15:11];
    assign funct         = instruction[5:0];
    assign unused_fields = {instruction[25:21], instruction[10:6]};

    always_comb begin
        ctrl = '0;
        case (opcode) inside
            OP_RTYPE: begin
                case (funct) inside
                    [6'b100000:6'b100111], F_SLT, F_SLTU: begin
                        ctrl.af         = funct[3:0];
                        ctrl.cad        = rd;
                        ctrl.gp_we      = 1'b1;
                        ctrl.gp_mux_sel = GP_ALU;
                    end
                    F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
                        ctrl.shift_type = shift_code(funct);
                        ctrl.cad        = rd;
                        ctrl.gp_we      = 1'b1;
                        ctrl.gp_mux_sel = GP_SHIFT;
                    end
                    F_JR: ctrl.pc_mux_sel = PC_RS;
                    F_JALR: begin
                        ctrl.pc_mux_sel = PC_RS;
                        ctrl.cad        = rd;
                        ctrl.gp_we      = 1'b1;
                        ctrl.gp_mux_sel = GP_LINK;
                    end
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                if (rt == RT_BLTZ || rt == RT_BGEZ) begin
                    ctrl.i          = 1'b1;
                    ctrl.pc_mux_sel = PC_BRANCH;
                    ctrl.bf         = (rt == RT_BLTZ) ? BF_BLTZ : BF_BGEZ;
                end
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
                ctrl.i          = 1'b1;
                ctrl.pc_mux_sel = PC_BRANCH;
                ctrl.bf         = {1'b0, opcode[2:0]} - 4'd1;
            end
            OP_J: ctrl.pc_mux_sel = PC_JUMP;
            OP_JAL: begin
                ctrl.pc_mux_sel = PC_JUMP;
                ctrl.cad        = 5'd31;
                ctrl.gp_we      = 1'b1;
                ctrl.gp_mux_sel = GP_LINK;
            end
            [6'b001000:6'b001111]: begin
                ctrl.af          = (opcode == OP_LUI) ? AF_LUI : {1'b0, opcode[2:0]};
                ctrl.i           = 1'b1;
                ctrl.alu_mux_sel = 1'b1;
                ctrl.cad         = rt;
                ctrl.gp_we       = 1'b1;
                ctrl.gp_mux_sel  = GP_ALU;
            end
            OP_LW: begin
                ctrl.af          = AF_ADD;
                ctrl.i           = 1'b1;
                ctrl.alu_mux_sel = 1'b1;
                ctrl.cad         = rt;
                ctrl.gp_we       = 1'b1;
                ctrl.gp_mux_sel  = GP_MEM;
            end
            OP_SW: begin
                ctrl.af          = AF_ADD;
                ctrl.i           = 1'b1;
                ctrl.alu_mux_sel = 1'b1;
                ctrl.dm_we       = 1'b1;
            end
            default: ;
        endcase
        // A stale write address is never exposed when nothing is written.
        if (!ctrl.gp_we) begin
            ctrl.cad = '0;
        end
    end

endmodule

// File: rtl/instr_decoder.sv
// Registered MIPS-style instruction decoder feeding ALU, shifter, register file, memory and PC.
// Latency: 1 clk from instruction to control outputs. Backpressure: none, accepts a word every cycle.
module instr_decoder
    import instr_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    output logic [3:0]  af,
    output logic        i,
    output logic        ALU_MUX_SEL,
    output logic [4:0]  cad,
    output logic        GP_WE,
    output logic [1:0]  GP_MUX_SEL,
    output logic [3:0]  bf,
    output logic        DM_WE,
    output logic [2:0]  Shift_type,
    output logic [1:0]  PC_MUX_SEL
);

    ctrl_t ctrl_nxt;
    ctrl_t ctrl_q;

    instr_decode_comb u_decode (
        .instruction (instruction),
        .ctrl        (ctrl_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_nxt;
        end
    end

    assign af          = ctrl_q.af;
    assign i           = ctrl_q.i;
    assign ALU_MUX_SEL = ctrl_q.alu_mux_sel;
    assign cad         = ctrl_q.cad;
    assign GP_WE       = ctrl_q.gp_we;
    assign GP_MUX_SEL  = ctrl_q.gp_mux_sel;
    assign bf          = ctrl_q.bf;
    assign DM_WE       = ctrl_q.dm_we;
    assign Shift_type  = ctrl_q.shift_type;
    assign PC_MUX_SEL  = ctrl_q.pc_mux_sel;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed vectors for instr_decoder; expected control words are queued at issue and
// checked by a separate monitor one clock later.
module tb_instr_decoder;

    typedef struct packed {
        logic [3:0] af;
        logic       i;
        logic       alu;
        logic [4:0] cad;
        logic       we;
        logic [1:0] gm;
        logic [3:0] bf;
        logic       dm;
        logic [2:0] sh;
        logic [1:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic [3:0]  af;
    logic        i;
    logic        ALU_MUX_SEL;
    logic [4:0]  cad;
    logic        GP_WE;
    logic [1:0]  GP_MUX_SEL;
    logic [3:0]  bf;
    logic        DM_WE;
    logic [2:0]  Shift_type;
    logic [1:0]  PC_MUX_SEL;
    exp_t        act;

    int total = 0;
    int bad   = 0;

    exp_t  exp_q[$];
    string name_q[$];

    instr_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .af          (af),
        .i           (i),
        .ALU_MUX_SEL (ALU_MUX_SEL),
        .cad         (cad),
        .GP_WE       (GP_WE),
        .GP_MUX_SEL  (GP_MUX_SEL),
        .bf          (bf),
        .DM_WE       (DM_WE),
        .Shift_type  (Shift_type),
        .PC_MUX_SEL  (PC_MUX_SEL)
    );

    always #5 clk = ~clk;

    assign act = {af, i, ALU_MUX_SEL, cad, GP_WE, GP_MUX_SEL, bf, DM_WE, Shift_type, PC_MUX_SEL};

    function automatic exp_t mk(input logic [3:0] f_af, input logic f_i, input logic f_alu,
                                input logic [4:0] f_cad, input logic f_we, input logic [1:0] f_gm,
                                input logic [3:0] f_bf, input logic f_dm, input logic [2:0] f_sh,
                                input logic [1:0] f_pc);
        exp_t e;
        e = '{f_af, f_i, f_alu, f_cad, f_we, f_gm, f_bf, f_dm, f_sh, f_pc};
        return e;
    endfunction

    task automatic check_now(input string nm, input exp_t want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic apply(input logic [31:0] ins, input exp_t e, input string nm);
        @(negedge clk);
        instruction = ins;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: an entry queued before a rising edge is the word captured at that edge.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            if (exp_q.size() > 0) begin
                @(negedge clk);
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check_now(nm, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout want finish");
        $fatal(1, "watchdog");
    end

    localparam int NV = 22;
    logic [31:0] vec_ins [NV];
    exp_t        vec_exp [NV];
    string       vec_nm  [NV];

    initial begin
        //                        af     i     alu   cad    we    gm     bf     dm    sh      pc
        vec_ins[0]  = 32'hAC850004; vec_exp[0]  = mk(4'h0, 1'b1, 1'b1, 5'd0,  1'b0, 2'b00, 4'h0, 1'b1, 3'b000, 2'b00); vec_nm[0]  = "sw";
        vec_ins[1]  = 32'h00852020; vec_exp[1]  = mk(4'h0, 1'b0, 1'b0, 5'd4,  1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[1]  = "add";
        vec_ins[2]  = 32'h00852040; vec_exp[2]  = mk(4'h0, 1'b0, 1'b0, 5'd4,  1'b1, 2'b11, 4'h0, 1'b0, 3'b001, 2'b00); vec_nm[2]  = "sll";
        vec_ins[3]  = 32'h10810004; vec_exp[3]  = mk(4'h0, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00, 4'h3, 1'b0, 3'b000, 2'b01); vec_nm[3]  = "beq";
        vec_ins[4]  = 32'h0C000009; vec_exp[4]  = mk(4'h0, 1'b0, 1'b0, 5'd31, 1'b1, 2'b10, 4'h0, 1'b0, 3'b000, 2'b10); vec_nm[4]  = "jal";
        vec_ins[5]  = 32'h00852008; vec_exp[5]  = mk(4'h0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 4'h0, 1'b0, 3'b000, 2'b11); vec_nm[5]  = "jr";
        vec_ins[6]  = 32'hFC000000; vec_exp[6]  = mk(4'h0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[6]  = "illegal_op";
        vec_ins[7]  = 32'h00852022; vec_exp[7]  = mk(4'h2, 1'b0, 1'b0, 5'd4,  1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[7]  = "sub";
        vec_ins[8]  = 32'h0085202A; vec_exp[8]  = mk(4'hA, 1'b0, 1'b0, 5'd4,  1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[8]  = "slt";
        vec_ins[9]  = 32'h00852027; vec_exp[9]  = mk(4'h7, 1'b0, 1'b0, 5'd4,  1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[9]  = "nor";
        vec_ins[10] = 32'h00852007; vec_exp[10] = mk(4'h0, 1'b0, 1'b0, 5'd4,  1'b1, 2'b11, 4'h0, 1'b0, 3'b111, 2'b00); vec_nm[10] = "srav";
        vec_ins[11] = 32'h00852002; vec_exp[11] = mk(4'h0, 1'b0, 1'b0, 5'd4,  1'b1, 2'b11, 4'h0, 1'b0, 3'b010, 2'b00); vec_nm[11] = "srl";
        vec_ins[12] = 32'h00852009; vec_exp[12] = mk(4'h0, 1'b0, 1'b0, 5'd4,  1'b1, 2'b10, 4'h0, 1'b0, 3'b000, 2'b11); vec_nm[12] = "jalr";
        vec_ins[13] = 32'h34A50010; vec_exp[13] = mk(4'h5, 1'b1, 1'b1, 5'd5,  1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[13] = "ori";
        vec_ins[14] = 32'h3C050010; vec_exp[14] = mk(4'hC, 1'b1, 1'b1, 5'd5,  1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[14] = "lui";
        vec_ins[15] = 32'h04800004; vec_exp[15] = mk(4'h0, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00, 4'h1, 1'b0, 3'b000, 2'b01); vec_nm[15] = "bltz";
        vec_ins[16] = 32'h04810004; vec_exp[16] = mk(4'h0, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00, 4'h2, 1'b0, 3'b000, 2'b01); vec_nm[16] = "bgez";
        vec_ins[17] = 32'h04820004; vec_exp[17] = mk(4'h0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[17] = "regimm_bad_rt";
        vec_ins[18] = 32'h1C800004; vec_exp[18] = mk(4'h0, 1'b1, 1'b0, 5'd0,  1'b0, 2'b00, 4'h6, 1'b0, 3'b000, 2'b01); vec_nm[18] = "bgtz";
        vec_ins[19] = 32'h08000010; vec_exp[19] = mk(4'h0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 4'h0, 1'b0, 3'b000, 2'b10); vec_nm[19] = "j";
        vec_ins[20] = 32'h00852001; vec_exp[20] = mk(4'h0, 1'b0, 1'b0, 5'd0,  1'b0, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[20] = "bad_funct";
        vec_ins[21] = 32'h8C850004; vec_exp[21] = mk(4'h0, 1'b1, 1'b1, 5'd5,  1'b1, 2'b01, 4'h0, 1'b0, 3'b000, 2'b00); vec_nm[21] = "lw_again";
    end

    initial begin
        exp_t lw_exp;
        exp_t zero_exp;
        exp_t add_exp;
        zero_exp = '0;
        lw_exp   = mk(4'h0, 1'b1, 1'b1, 5'd5, 1'b1, 2'b01, 4'h0, 1'b0, 3'b000, 2'b00);
        add_exp  = mk(4'h0, 1'b0, 1'b0, 5'd4, 1'b1, 2'b00, 4'h0, 1'b0, 3'b000, 2'b00);

        rst_n       = 1'b0;
        instruction = 32'h8C850004;
        repeat (3) @(negedge clk);
        check_now("reset_clear", zero_exp);

        // Release away from the edge with LW already on the bus; it must land on the next edge.
        rst_n = 1'b1;
        exp_q.push_back(lw_exp);
        name_q.push_back("lw_after_reset");

        for (int k = 0; k < NV; k++) begin
            apply(vec_ins[k], vec_exp[k], vec_nm[k]);
        end

        apply(32'h00852020, add_exp, "add_before_arst");
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_now("async_reset_midcycle", zero_exp);
        @(negedge clk);
        rst_n = 1'b1;
        apply(32'h0C000009, mk(4'h0, 1'b0, 1'b0, 5'd31, 1'b1, 2'b10, 4'h0, 1'b0, 3'b000, 2'b10), "jal_after_arst");

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
